// File: rtl/bs_pkg.sv
// Shared bitstream constants, consume-source encoding and align-length helper.
// Used by the bit window reader and the exp-Golomb / CAVLC parsers.
// No logic of its own.
package bs_pkg;

    localparam int WORD_W  = 16;
    localparam int WIN_W   = 48;
    localparam int FILL_W  = 6;
    localparam int LEN_W   = 5;
    localparam int MAX_FWD = 16;

    typedef enum logic [1:0] {
        CONS_NONE  = 2'd0,
        CONS_FWD   = 2'd1,
        CONS_ALIGN = 2'd2
    } cons_src_t;

    // Bits needed to reach the next byte boundary: (8 - pos[2:0]) mod 8.
    function automatic logic [LEN_W-1:0] align_len(input logic [2:0] pos_lsb);
        logic [2:0] r;
        r = 3'd0 - pos_lsb;
        return {2'b00, r};
    endfunction

endpackage

// File: rtl/bs_window_shift.sv
// Combinational shift-and-insert of the left-aligned bit window.
// Latency: none (pure combinational).
// Backpressure: none; caller guarantees len_i <= fill_i and push only when fill_i <= 32.
module bs_window_shift
    import bs_pkg::*;
(
    input  logic [WIN_W-1:0]  win_i,
    input  logic [FILL_W-1:0] fill_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [WIN_W-1:0]  win_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [FILL_W-1:0] offset;
    logic [WIN_W-1:0]  shifted;
    logic [WIN_W-1:0]  inserted;
    logic [WIN_W-1:0]  keep_mask;
    logic [WIN_W-1:0]  word_top;

    always_comb begin
        offset   = fill_i - {1'b0, len_i};
        shifted  = win_i << len_i;
        word_top = {word_i, {(WIN_W-WORD_W){1'b0}}};
        inserted = '0;
        fill_o   = offset;
        if (push_i) begin
            // New word lands right after the last surviving bit.
            inserted = word_top >> offset;
            fill_o   = offset + FILL_W'(WORD_W);
        end
        // Everything past the fill level is forced to zero.
        keep_mask = ~({WIN_W{1'b1}} >> fill_o);
        win_o     = (shifted | inserted) & keep_mask;
    end

endmodule

// File: rtl/bitstream_reader.sv
// Bit window reader: buffers 16-bit RBSP words, presents next 16 bits MSB-first.
// Latency: consume/push visible on bits_out/fill_cnt one cycle later.
// Backpressure: ao_next decoded from registered fill only (high while fill <= ACCEPT_MAX).
module bitstream_reader
    import bs_pkg::*;
#(
    parameter int POS_W      = 24,
    parameter int ACCEPT_MAX = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ai_we,
    input  logic [15:0]       ai_data,
    output logic              ao_next,
    input  logic              flush,
    input  logic              fwd_en,
    input  logic [4:0]        fwd_len,
    input  logic              align_en,
    output logic [15:0]       bits_out,
    output logic              bits_valid,
    output logic [5:0]        fill_cnt,
    output logic              byte_aligned,
    output logic [POS_W-1:0]  bit_pos,
    output logic              under_err
);

    logic [WIN_W-1:0]  window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              err_q, err_d;

    cons_src_t         cons_src;
    logic [LEN_W-1:0]  len_req;
    logic [LEN_W-1:0]  len_eff;
    logic              refuse;
    logic              push;
    logic [WIN_W-1:0]  win_nxt;
    logic [FILL_W-1:0] fill_nxt;

    assign ao_next = (fill_q <= FILL_W'(ACCEPT_MAX));
    assign push    = ai_we && ao_next;

    always_comb begin
        cons_src = CONS_NONE;
        if (fwd_en) begin
            cons_src = CONS_FWD;
        end else if (align_en) begin
            cons_src = CONS_ALIGN;
        end

        case (cons_src)
            CONS_FWD:   len_req = fwd_len;
            CONS_ALIGN: len_req = align_len(pos_q[2:0]);
            default:    len_req = '0;
        endcase

        // Out-of-range lengths are refused the same way as an underrun.
        refuse  = ({1'b0, len_req} > fill_q) || (len_req > LEN_W'(MAX_FWD));
        len_eff = refuse ? '0 : len_req;
    end

    bs_window_shift u_shift (
        .win_i  (window_q),
        .fill_i (fill_q),
        .len_i  (len_eff),
        .push_i (push),
        .word_i (ai_data),
        .win_o  (win_nxt),
        .fill_o (fill_nxt)
    );

    always_comb begin
        window_d = win_nxt;
        fill_d   = fill_nxt;
        pos_d    = pos_q + POS_W'(len_eff);
        err_d    = refuse;
        // Flush wins over everything, including the word offered this cycle.
        if (flush) begin
            window_d = '0;
            fill_d   = '0;
            pos_d    = '0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_q <= '0;
            fill_q   <= '0;
            pos_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            pos_q    <= pos_d;
            err_q    <= err_d;
        end
    end

    assign bits_out     = window_q[WIN_W-1 -: WORD_W];
    assign bits_valid   = (fill_q >= FILL_W'(WORD_W));
    assign fill_cnt     = fill_q;
    assign byte_aligned = (pos_q[2:0] == 3'd0);
    assign bit_pos      = pos_q;
    assign under_err    = err_q;

endmodule

// File: tb/tb_bitstream_reader.sv
// Directed bench for bitstream_reader with hand-computed expectations.
module tb_bitstream_reader;

    logic        clk;
    logic        reset_n;
    logic        ai_we;
    logic [15:0] ai_data;
    logic        ao_next;
    logic        flush;
    logic        fwd_en;
    logic [4:0]  fwd_len;
    logic        align_en;
    logic [15:0] bits_out;
    logic        bits_valid;
    logic [5:0]  fill_cnt;
    logic        byte_aligned;
    logic [23:0] bit_pos;
    logic        under_err;

    int total = 0;
    int bad   = 0;

    bitstream_reader #(.POS_W(24), .ACCEPT_MAX(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ai_we        (ai_we),
        .ai_data      (ai_data),
        .ao_next      (ao_next),
        .flush        (flush),
        .fwd_en       (fwd_en),
        .fwd_len      (fwd_len),
        .align_en     (align_en),
        .bits_out     (bits_out),
        .bits_valid   (bits_valid),
        .fill_cnt     (fill_cnt),
        .byte_aligned (byte_aligned),
        .bit_pos      (bit_pos),
        .under_err    (under_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        ai_we    = 1'b0;
        ai_data  = 16'h0;
        flush    = 1'b0;
        fwd_en   = 1'b0;
        fwd_len  = 5'd0;
        align_en = 1'b0;

        step();
        chk("rst_fill",   32'(fill_cnt), 32'd0);
        chk("rst_bits",   32'(bits_out), 32'h0);
        chk("rst_next",   32'(ao_next), 32'd1);
        chk("rst_valid",  32'(bits_valid), 32'd0);
        chk("rst_pos",    32'(bit_pos), 32'd0);
        chk("rst_err",    32'(under_err), 32'd0);
        reset_n = 1'b1;
        step();

        // Two pushes, no consume
        ai_we = 1'b1; ai_data = 16'h1234; step();
        ai_data = 16'h5678; step();
        ai_we = 1'b0;
        chk("push2_fill",  32'(fill_cnt), 32'd32);
        chk("push2_bits",  32'(bits_out), 32'h1234);
        chk("push2_valid", 32'(bits_valid), 32'd1);
        chk("push2_next",  32'(ao_next), 32'd1);

        // Consume 4
        fwd_en = 1'b1; fwd_len = 5'd4; step();
        fwd_en = 1'b0;
        chk("fwd4_bits",  32'(bits_out), 32'h2345);
        chk("fwd4_fill",  32'(fill_cnt), 32'd28);
        chk("fwd4_pos",   32'(bit_pos), 32'd4);
        chk("fwd4_align", 32'(byte_aligned), 32'd0);

        // Align: drops 4 bits
        align_en = 1'b1; step();
        align_en = 1'b0;
        chk("aln_bits",  32'(bits_out), 32'h3456);
        chk("aln_fill",  32'(fill_cnt), 32'd24);
        chk("aln_pos",   32'(bit_pos), 32'd8);
        chk("aln_align", 32'(byte_aligned), 32'd1);

        // Flush, then fill to 48
        flush = 1'b1; step();
        flush = 1'b0;
        chk("fl1_fill", 32'(fill_cnt), 32'd0);
        chk("fl1_pos",  32'(bit_pos), 32'd0);
        ai_we = 1'b1; ai_data = 16'hAAAA; step();
        ai_data = 16'hBBBB; step();
        ai_data = 16'hCCCC; step();
        chk("full_fill", 32'(fill_cnt), 32'd48);
        chk("full_next", 32'(ao_next), 32'd0);
        ai_data = 16'hDDDD; step();
        chk("held_fill", 32'(fill_cnt), 32'd48);
        chk("held_bits", 32'(bits_out), 32'hAAAA);
        fwd_en = 1'b1; fwd_len = 5'd16; step();
        fwd_en = 1'b0;
        chk("drain_fill", 32'(fill_cnt), 32'd32);
        chk("drain_next", 32'(ao_next), 32'd1);
        chk("drain_bits", 32'(bits_out), 32'hBBBB);
        step();
        ai_we = 1'b0;
        chk("acc_fill", 32'(fill_cnt), 32'd48);
        chk("acc_bits", 32'(bits_out), 32'hBBBB);
        fwd_en = 1'b1; fwd_len = 5'd16; step();
        fwd_en = 1'b0;
        chk("c2_bits", 32'(bits_out), 32'hCCCC);
        fwd_en = 1'b1; fwd_len = 5'd16; step();
        fwd_en = 1'b0;
        chk("c3_bits", 32'(bits_out), 32'hDDDD);
        chk("c3_fill", 32'(fill_cnt), 32'd16);

        // Underrun refusal
        flush = 1'b1; step();
        flush = 1'b0;
        ai_we = 1'b1; ai_data = 16'hF0F0; step();
        ai_we = 1'b0;
        fwd_en = 1'b1; fwd_len = 5'd4; step();
        chk("u_fill",  32'(fill_cnt), 32'd12);
        chk("u_bits",  32'(bits_out), 32'h0F00);
        fwd_len = 5'd13; step();
        fwd_en = 1'b0;
        chk("u13_err",  32'(under_err), 32'd1);
        chk("u13_fill", 32'(fill_cnt), 32'd12);
        chk("u13_pos",  32'(bit_pos), 32'd4);
        chk("u13_bits", 32'(bits_out), 32'h0F00);
        step();
        chk("u_pulse_end", 32'(under_err), 32'd0);
        fwd_en = 1'b1; fwd_len = 5'd12; step();
        fwd_en = 1'b0;
        chk("u12_fill", 32'(fill_cnt), 32'd0);
        chk("u12_bits", 32'(bits_out), 32'h0000);
        chk("u12_pos",  32'(bit_pos), 32'd16);
        chk("u12_err",  32'(under_err), 32'd0);

        // Simultaneous push and consume at fill 16
        ai_we = 1'b1; ai_data = 16'hC3C3; step();
        chk("s_pre_fill", 32'(fill_cnt), 32'd16);
        ai_data = 16'h00FF; fwd_en = 1'b1; fwd_len = 5'd16; step();
        ai_we = 1'b0; fwd_en = 1'b0;
        chk("s_fill", 32'(fill_cnt), 32'd16);
        chk("s_bits", 32'(bits_out), 32'h00FF);
        chk("s_pos",  32'(bit_pos), 32'd32);

        // Zero-length consume is a no-op
        fwd_en = 1'b1; fwd_len = 5'd0; step();
        fwd_en = 1'b0;
        chk("z_fill", 32'(fill_cnt), 32'd16);
        chk("z_pos",  32'(bit_pos), 32'd32);
        chk("z_err",  32'(under_err), 32'd0);

        // Flush with concurrent push and consume
        ai_we = 1'b1; ai_data = 16'h1111; fwd_en = 1'b1; fwd_len = 5'd4; flush = 1'b1; step();
        ai_we = 1'b0; fwd_en = 1'b0; flush = 1'b0;
        chk("fl2_fill", 32'(fill_cnt), 32'd0);
        chk("fl2_pos",  32'(bit_pos), 32'd0);
        chk("fl2_err",  32'(under_err), 32'd0);
        chk("fl2_bits", 32'(bits_out), 32'h0);

        // Asynchronous reset mid-stream
        ai_we = 1'b1; ai_data = 16'hABCD; step();
        ai_data = 16'h1357; step();
        ai_we = 1'b0;
        fwd_en = 1'b1; fwd_len = 5'd3; step();
        fwd_en = 1'b0;
        chk("m_bits", 32'(bits_out), 32'h5E68);
        chk("m_pos",  32'(bit_pos), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_fill",  32'(fill_cnt), 32'd0);
        chk("ar_bits",  32'(bits_out), 32'h0);
        chk("ar_pos",   32'(bit_pos), 32'd0);
        chk("ar_next",  32'(ao_next), 32'd1);
        chk("ar_valid", 32'(bits_valid), 32'd0);
        chk("ar_align", 32'(byte_aligned), 32'd1);
        step();
        reset_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitstream_reader.md
Name: bitstream_reader

Overview:
- Sits directly downstream of the emulation-prevention (0x03 removal) stage in the H.264 front end.
- Accepts cleaned 16-bit RBSP words over the same `we`/`next` handshake and buffers them in a 48-bit left-aligned bit window.
- Presents the next 16 unconsumed bits, MSB-first, to syntax parsers (exp-Golomb, slice header, CAVLC).
- Supports variable-length consume (0..16 bits), byte alignment, NAL flush and a running bit-position counter.

Parameters:
- POS_W, 24, width of the consumed-bit position counter (wraps modulo 2^POS_W).
- ACCEPT_MAX, 32, maximum fill level at which a new input word is still accepted (must be <= 32).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ai_we  input  1  upstream word valid.
- ai_data  input  16  upstream word; bits [15:8] are the earlier byte in the stream.
- ao_next  output  1  ready; a word transfers on a cycle with ai_we && ao_next.
- flush  input  1  synchronous clear of the window (start of a new NAL unit).
- fwd_en  input  1  consume request.
- fwd_len  input  5  bits to consume, 0..16; values above 16 are illegal.
- align_en  input  1  discard bits up to the next byte boundary.
- bits_out  output  16  next 16 unconsumed bits, MSB = oldest; zero-padded beyond fill.
- bits_valid  output  1  fill_cnt >= 16.
- fill_cnt  output  6  number of valid bits in the window, 0..48.
- byte_aligned  output  1  bit_pos[2:0] == 0.
- bit_pos  output  POS_W  total bits consumed since reset or flush.
- under_err  output  1  one-cycle pulse when a consume or align is refused.

Behaviour:
- Reset values: window = 0, fill_cnt = 0, bit_pos = 0, under_err = 0, bits_valid = 0, ao_next = 1, bits_out = 0.
- ao_next = (fill_cnt <= ACCEPT_MAX). It is decoded from the registered fill only; there is no combinational path from fwd_en or ai_we.
- Consume length L per cycle:
  - fwd_en: L = fwd_len.
  - align_en with fwd_en low: L = (8 - bit_pos[2:0]) mod 8.
  - Otherwise: L = 0.
  - fwd_en has priority; align_en is ignored in the same cycle.
- Legality: if L > fill_cnt, no bits are consumed, bit_pos is unchanged, and under_err pulses high the next cycle. A push in the same cycle still proceeds.
- Single-cycle update with push P = ai_we && ao_next:
  - window_next = (window << L) with ai_data inserted at bit offset (fill_cnt - L) from the MSB when P.
  - fill_next = fill_cnt - L + (P ? 16 : 0).
  - Simultaneous consume and push is legal and the common case.
- Latency: a consume is visible on bits_out and fill_cnt the next cycle. A pushed word is visible the next cycle.
- bit_pos += L on each legal consume, including align. It wraps at 2^POS_W with no flag.
- Bits beyond fill_cnt in the window are forced to 0, so bits_out is deterministic when fill_cnt < 16.
- flush has the highest priority:
  - Next cycle: window = 0, fill_cnt = 0, bit_pos = 0.
  - Any push or consume in the flush cycle is discarded. Upstream sees ao_next high, so that word is dropped by design.
  - under_err is not raised by flush.
- fwd_len = 0 is a legal no-op and never errors.
- Full boundary: at fill_cnt = 32 a word is accepted (reaching 48). At 33..48, ao_next = 0 and the upstream word is held.
- Reset asserted mid-operation clears all state immediately; the buffered data is lost.

Decomposition:
- Shared package `bs_pkg`:
  - WORD_W = 16, WIN_W = 48, FILL_W = 6.
  - Illegal-length constant MAX_FWD = 16.
  - These are shared with the exp-Golomb and CAVLC parsers.
- One sub-module, `bs_window_shift`: combinational shift-and-insert of the 48-bit window given L, fill and the push word. The top level keeps the registers, handshake, counters and error logic.

Test Plan:
- Reset, then push words 0x1234 and 0x5678 with no consume -> fill_cnt = 32, bits_out = 0x1234, bits_valid = 1, ao_next = 1.
- From that state, fwd_len = 4 -> next cycle bits_out = 0x2345, fill_cnt = 28, bit_pos = 4, byte_aligned = 0. Then align_en -> bits_out = 0x3456, fill_cnt = 24, bit_pos = 8, byte_aligned = 1.
- Fill to 48 with 0xAAAA, 0xBBBB, 0xCCCC while ai_we stays high with 0xDDDD -> ao_next = 0, word held. Then fwd_len = 16 -> fill 32, ao_next = 1. Then 0xDDDD is accepted and bits_out = 0xBBBB.
- fill_cnt = 12 (push 0xF0F0, consume 4), then fwd_len = 13 -> no change, under_err pulses once, bit_pos = 4. fwd_len = 12 in the same state -> fill_cnt = 0, bits_out = 0x0000.
- Simultaneous push of 0x00FF and fwd_len = 16 at fill_cnt = 16 -> fill_cnt stays 16, bits_out = 0x00FF, bit_pos += 16.
- flush asserted together with ai_we and fwd_en -> next cycle fill_cnt = 0, bit_pos = 0, under_err = 0, input word dropped. Async reset pulse mid-stream -> all outputs at reset values.
